// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF sync, oversampled start/data/stop sampling, valid/ready output.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DW = $clog2(BAUD_DIV + 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE, BRK
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [DW-1:0]        div;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_bit;
  logic                 tick, bit_end, half_bit;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
`endif

  assign tick     = (div == DW'(BAUD_DIV - 1));
  assign bit_end  = tick && (os_cnt == OW'(OVERSAMPLE - 1));
  assign half_bit = tick && (os_cnt == OW'(OVERSAMPLE / 2 - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      div        <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      stop_bit   <= 1'b1;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      div     <= tick ? '0 : div + 1'b1;
      overrun <= 1'b0;
      // os_cnt free-runs per bit; state arms below override it where a phase is re-aligned
      if (tick) os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: if (!rx_s) begin
          state  <= START;
          div    <= '0;
          os_cnt <= '0;
        end
        START: if (half_bit) begin
          os_cnt <= '0;
          if (!rx_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: if (bit_end) begin
          shift   <= {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          par_bit <= rx_s;
          state   <= STOP;
        end
`endif
        STOP: if (bit_end) begin
          stop_bit <= rx_s;
          state    <= DONE;
        end
        DONE: begin
          // a completing frame wins over a same-cycle handshake clear
          data       <= shift;
          data_valid <= 1'b1;
          overrun    <= data_valid && !data_ready;
          frame_err  <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
          parity_err <= ((^shift) ^ par_bit) != 1'(PARITY_ODD);
`else
          parity_err <= 1'b0;
`endif
          state      <= stop_bit ? IDLE : BRK;
        end
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (8 data bits, 16x oversample, 4 clks/tick, 64 clks/bit).
// Define UART_RX_PARITY_EN to exercise the even-parity build.
module tb_uart_rx_param;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid, data_ready = 1'b1;
  logic       frame_err, parity_err, overrun, busy;

  int n_tests = 0, n_fail = 0;
  int frame_cnt = 0, dv_cycles = 0, ov_cnt = 0;
  logic [7:0] cap_data = '0;
  logic cap_fe = 1'b0, cap_pe = 1'b0, dv_prev = 1'b0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record each newly reported frame (rising valid, or overwrite flagged by overrun)
  always @(negedge clk) begin
    if (data_valid && (!dv_prev || overrun)) begin
      frame_cnt++;
      cap_data = data;
      cap_fe   = frame_err;
      cap_pe   = parity_err;
    end
    if (data_valid) dv_cycles++;
    if (overrun) ov_cnt++;
    dv_prev = data_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (BIT) @(negedge clk);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[5];

  int f0, c0, o0;

  initial begin
    vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{tx: 8'h3C, stop: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{tx: 8'h00, stop: 1'b1, exp_fe: 1'b0};
    vecs[3] = '{tx: 8'hFF, stop: 1'b1, exp_fe: 1'b0};
    vecs[4] = '{tx: 8'h81, stop: 1'b1, exp_fe: 1'b0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (BIT) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      f0 = frame_cnt; c0 = dv_cycles; o0 = ov_cnt;
      send_frame(vecs[v].tx, vecs[v].stop, ^vecs[v].tx);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check($sformatf("vec%0d_count", v), 32'(frame_cnt), 32'(f0 + 1));
      check($sformatf("vec%0d_data", v), 32'(cap_data), 32'(vecs[v].tx));
      check($sformatf("vec%0d_ferr", v), 32'(cap_fe), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_perr", v), 32'(cap_pe), 32'h0);
      check($sformatf("vec%0d_valid_len", v), 32'(dv_cycles), 32'(c0 + 1));
      check($sformatf("vec%0d_overrun", v), 32'(ov_cnt), 32'(o0));
      check($sformatf("vec%0d_idle", v), 32'(busy), 32'h0);
    end

    // 20-clk glitch: start rejected at mid start bit
    f0 = frame_cnt;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'h1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_frame", 32'(frame_cnt), 32'(f0));
    check("glitch_idle", 32'(busy), 32'h0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("post_glitch_count", 32'(frame_cnt), 32'(f0 + 1));
    check("post_glitch_data", 32'(cap_data), 32'h3C);

    // Low stop bit then line held low: framing error, break, no phantom frames
    f0 = frame_cnt;
    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (10 * BIT) @(negedge clk);
    check("break_count", 32'(frame_cnt), 32'(f0 + 1));
    check("break_data", 32'(cap_data), 32'h55);
    check("break_ferr", 32'(cap_fe), 32'h1);
    check("break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("break_released", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1, ^8'h81);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("post_break_count", 32'(frame_cnt), 32'(f0 + 2));
    check("post_break_data", 32'(cap_data), 32'h81);
    check("post_break_ferr", 32'(cap_fe), 32'h0);

    // Back-to-back frames with consumer stalled: single overrun, latest data kept
    f0 = frame_cnt; o0 = ov_cnt;
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("ovr_pulses", 32'(ov_cnt), 32'(o0 + 1));
    check("ovr_frames", 32'(frame_cnt), 32'(f0 + 2));
    check("ovr_data", 32'(data), 32'h22);
    check("ovr_valid_held", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    @(negedge clk);
    check("ovr_accept", 32'(data_valid), 32'h0);

    // Reset in the middle of data bit 4 aborts the frame silently
    f0 = frame_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    check("abort_no_frame", 32'(frame_cnt), 32'(f0));
    check("abort_data", 32'(data), 32'h0);
    check("abort_idle", 32'(busy), 32'h0);
    send_frame(8'hF0, 1'b1, ^8'hF0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("after_abort_count", 32'(frame_cnt), 32'(f0 + 1));
    check("after_abort_data", 32'(cap_data), 32'hF0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a parity bit of 1 is correct
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("par_ok_data", 32'(cap_data), 32'h07);
    check("par_ok_perr", 32'(cap_pe), 32'h0);
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("par_bad_perr", 32'(cap_pe), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
